// File: rtl/bitonic_batch_loader.sv
// Collects a valid/ready word stream into SIZE-wide batches for the bitonic sorter tree.
// Short batches are padded so the pads sort to the tail; out_count gives the real length.
module bitonic_batch_loader #(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 4,
  parameter int DIRECTION  = 0,
  parameter int SIZE       = 1 << DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VALUE_BITS-1:0]               in_value,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIZE-1:0][VALUE_BITS-1:0]     out_data,
  output logic [DEPTH:0]                      out_count
);

  localparam logic [VALUE_BITS-1:0] PAD       = (DIRECTION == 0) ? {VALUE_BITS{1'b1}} : '0;
  localparam logic [DEPTH:0]        LAST_SLOT = (DEPTH+1)'(SIZE - 1);

  logic [VALUE_BITS-1:0]            fill_q [SIZE];
  logic [DEPTH:0]                   cnt_q, cnt_d;
  logic                             sealed_q, sealed_d;
  logic                             out_valid_q, out_valid_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]  out_data_q, out_data_d;
  logic [DEPTH:0]                   out_count_q, out_count_d;

  logic                             accept, complete, out_free, load_out;
  logic [DEPTH:0]                   batch_n;
  logic [SIZE-1:0][VALUE_BITS-1:0]  batch_vec;

  assign in_ready  = !sealed_q;
  assign accept    = in_valid && !sealed_q;
  assign complete  = accept && (in_last || (cnt_q == LAST_SLOT));
  assign out_free  = !out_valid_q || out_ready;
  assign load_out  = (complete || sealed_q) && out_free;
  // A sealed batch already counts its last word; a completing one adds the word in flight.
  assign batch_n   = sealed_q ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      if ((DEPTH+1)'(i) >= batch_n)
        batch_vec[i] = PAD;
      else if (accept && ((DEPTH+1)'(i) == cnt_q))
        batch_vec[i] = in_value;
      else
        batch_vec[i] = fill_q[i];
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a latch behind.
    cnt_d       = cnt_q;
    sealed_d    = sealed_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (load_out) begin
      out_data_d  = batch_vec;
      out_count_d = batch_n;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      sealed_d    = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (accept)    cnt_d       = cnt_q + 1'b1;
      if (complete)  sealed_d    = 1'b1;
    end
  end

  // NOTE: state registers use <= so every register updates from pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sealed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sealed_q    <= sealed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  // NOTE: fill slots are not reset; cnt_q and the padding mask any stale contents.
  always_ff @(posedge clk) begin
    if (accept) fill_q[cnt_q[DEPTH-1:0]] <= in_value;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_bitonic_batch_loader.sv
// Bench for bitonic_batch_loader: scoreboard of expected batches plus directed corner cases.
module tb_bitonic_batch_loader;

  localparam int VB    = 8;
  localparam int DEPTH = 4;
  localparam int SIZE  = 16;
  localparam int W     = SIZE * VB;

  typedef struct {
    logic [W-1:0]   data;
    logic [DEPTH:0] count;
  } batch_t;

  typedef struct {
    int             len;
    logic [VB-1:0]  seed;
    logic [VB-1:0]  step;
    bit             last_on_final;
    logic [DEPTH:0] exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [VB-1:0]               in_value;
  logic [SIZE-1:0][VB-1:0]     out_data;
  logic [DEPTH:0]              out_count;

  logic                        d1_in_valid, d1_in_ready, d1_in_last, d1_out_valid, d1_out_ready;
  logic [VB-1:0]               d1_in_value;
  logic [SIZE-1:0][VB-1:0]     d1_out_data;
  logic [DEPTH:0]              d1_out_count;

  bitonic_batch_loader #(.VALUE_BITS(VB), .DEPTH(DEPTH), .DIRECTION(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  bitonic_batch_loader #(.VALUE_BITS(VB), .DEPTH(DEPTH), .DIRECTION(1)) dut_desc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_value(d1_in_value), .in_last(d1_in_last),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_count(d1_out_count)
  );

  int checks = 0;
  int errors = 0;

  batch_t         sb[$];
  batch_t         mon_e;
  logic [VB-1:0]  model_fill [SIZE];
  int             model_cnt = 0;
  int             hs_count = 0;
  int             valid_cycles = 0;
  bit             track_ready = 0;
  bit             ready_dropped = 0;
  bit             hold_prev = 0;
  logic [W-1:0]   prev_data;
  logic [DEPTH:0] prev_count;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the fill side: pushes the padded batch when a word closes it.
  task automatic model_accept(input logic [VB-1:0] v, input bit last);
    batch_t b;
    model_fill[model_cnt] = v;
    model_cnt++;
    if (last || model_cnt == SIZE) begin
      b.data = '1;
      for (int i = 0; i < model_cnt; i++) b.data[i*VB +: VB] = model_fill[i];
      b.count = (DEPTH+1)'(model_cnt);
      sb.push_back(b);
      model_cnt = 0;
    end
  endtask

  task automatic send_word(input logic [VB-1:0] v, input bit last);
    bit done = 0;
    bit rdy;
    in_valid = 1'b1;
    in_value = v;
    in_last  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (done) model_accept(v, last);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    model_cnt = 0;
  endtask

  always @(negedge rst_n) hold_prev = 0;

  always @(negedge clk) begin
    if (!rst_n) hold_prev = 0;
    else begin
      if (out_valid) valid_cycles++;
      if (track_ready && !in_ready) ready_dropped = 1;
      if (hold_prev) begin
        check("hold_data", out_data, prev_data);
        check("hold_count", out_count, prev_count);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_batch: got count %0d expected no batch", out_count);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", out_data, mon_e.data);
          check("sb_count", out_count, mon_e.count);
        end
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_count = out_count;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t         vecs [6];
  logic [W-1:0] exp_vec;
  int           hs_before;

  initial begin
    vecs[0] = '{16, 8'd0,   8'd1, 1'b1, 5'd16};
    vecs[1] = '{1,  8'hFF,  8'd0, 1'b1, 5'd1};
    vecs[2] = '{5,  8'd10,  8'd3, 1'b1, 5'd5};
    vecs[3] = '{15, 8'd200, 8'd7, 1'b1, 5'd15};
    vecs[4] = '{16, 8'd3,   8'd5, 1'b0, 5'd16};
    vecs[5] = '{2,  8'hFE,  8'd1, 1'b1, 5'd2};

    in_valid = 0; in_value = 0; in_last = 0; out_ready = 1;
    d1_in_valid = 0; d1_in_value = 0; d1_in_last = 0; d1_out_ready = 1;

    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Full batch streamed back-to-back
    valid_cycles = 0; ready_dropped = 0; track_ready = 1;
    for (int i = 0; i < SIZE; i++) send_word(VB'(i), 1'b0);
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_count", out_count, 16);
    @(posedge clk); #1;
    idle(3);
    track_ready = 0;
    check("t1_one_pulse", valid_cycles, 1);
    check("t1_ready_held", ready_dropped, 0);

    // Short batch closed by in_last
    send_word(8'd7, 0); send_word(8'd2, 0); send_word(8'd9, 1);
    @(negedge clk);
    exp_vec = '1; exp_vec[7:0] = 8'd7; exp_vec[15:8] = 8'd2; exp_vec[23:16] = 8'd9;
    check("t2_data", out_data, exp_vec);
    check("t2_count", out_count, 3);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].len; k++)
        send_word(VB'(vecs[v].seed + k * vecs[v].step), vecs[v].last_on_final && (k == vecs[v].len - 1));
      @(negedge clk);
      check("tbl_valid", out_valid, 1);
      check("tbl_count", out_count, vecs[v].exp_count);
      @(posedge clk); #1;
    end

    // Backpressure: first batch held, second sealed
    out_ready = 0;
    for (int i = 0; i < 2*SIZE; i++) send_word(VB'(100 + i), 1'b0);
    @(negedge clk);
    check("t3_sealed_ready", in_ready, 0);
    check("t3_valid", out_valid, 1);
    check("t3_first_elem", out_data[0], 100);
    @(posedge clk); #1;
    idle(1);
    out_ready = 1;
    @(negedge clk);
    check("t3_still_sealed", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    check("t3_b2_valid", out_valid, 1);
    check("t3_b2_count", out_count, 16);
    check("t3_b2_first", out_data[0], 116);
    check("t3_ready_back", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    idle(2);
    check("t3_sb_empty", sb.size(), 0);

    // Output taken on the same edge a new batch completes
    hs_before = hs_count;
    out_ready = 0;
    for (int i = 0; i < SIZE; i++) send_word(VB'(50 + i), 1'b0);
    send_word(8'd60, 0); send_word(8'd61, 0);
    out_ready = 1;
    send_word(8'd62, 1);
    @(negedge clk);
    check("t4_valid_stays", out_valid, 1);
    check("t4_count", out_count, 3);
    check("t4_first", out_data[0], 60);
    @(posedge clk); #1;
    idle(2);
    check("t4_handshakes", hs_count - hs_before, 2);
    check("t4_sb_empty", sb.size(), 0);

    // Descending instance pads with zero
    d1_in_valid = 1; d1_in_value = 8'd5; d1_in_last = 1;
    @(negedge clk);
    check("t5_ready", d1_in_ready, 1);
    @(posedge clk); #1;
    d1_in_valid = 0; d1_in_last = 0;
    @(negedge clk);
    check("t5_valid", d1_out_valid, 1);
    check("t5_data", d1_out_data, 128'h05);
    check("t5_count", d1_out_count, 1);
    @(negedge clk);
    check("t5_valid_drop", d1_out_valid, 0);
    @(posedge clk); #1;

    // Reset mid-batch
    for (int i = 0; i < 6; i++) send_word(VB'(30 + i), 1'b0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("t6a_out_valid", out_valid, 0);
    check("t6a_out_data", out_data, 0);
    check("t6a_out_count", out_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6a_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Reset while sealed
    out_ready = 0;
    for (int i = 0; i < 2*SIZE; i++) send_word(VB'(i * 3), 1'b0);
    @(negedge clk);
    check("t6b_sealed", in_ready, 0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("t6b_out_valid", out_valid, 0);
    check("t6b_out_data", out_data, 0);
    check("t6b_out_count", out_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    send_word(8'd200, 0); send_word(8'd201, 1);
    @(negedge clk);
    check("t6b_count", out_count, 2);
    check("t6b_slot0", out_data[0], 200);
    check("t6b_slot1", out_data[1], 201);
    @(posedge clk); #1;
    idle(2);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
